// File: rtl/btn_pkg.sv
// Shared constants and state encoding for the push-button conditioning block.
package btn_pkg;

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    REL   = 2'd0,
    PQUAL = 2'd1,
    PRESS = 2'd2,
    RQUAL = 2'd3
  } btn_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: metastability synchronizer, tick-paced debounce FSM, level register.
// arm_c is high combinationally on the tick cycle where a press is accepted.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_TICKS  = 3,
  parameter bit          RAW_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic arm_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   raw_pressed;
  logic                   s;

  btn_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   cnt_done;

  assign raw_pressed = RAW_ACTIVE_HIGH ? raw : ~raw;
  assign s           = sync_q[SYNC_STAGES-1];
  assign cnt_done    = (cnt_q == CNT_W'(DEBOUNCE_TICKS));

  // Synchronizer runs every clock; reset value means "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_pressed};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REL;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Debounce transitions only advance on tick cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    arm_c   = 1'b0;
    if (tick) begin
      unique case (state_q)
        REL: begin
          if (s) begin
            state_d = PQUAL;
            cnt_d   = CNT_W'(1);
          end
        end
        PQUAL: begin
          if (!s) begin
            state_d = REL;
          end else if (cnt_done) begin
            state_d = PRESS;
            level_d = 1'b1;
            arm_c   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PRESS: begin
          if (!s) begin
            state_d = RQUAL;
            cnt_d   = CNT_W'(1);
          end
        end
        RQUAL: begin
          if (s) begin
            state_d = PRESS;
          end else if (cnt_done) begin
            state_d = REL;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = REL;
      endcase
    end
  end

  assign level = level_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// Debounced one-press pulses for four buttons, each high for exactly one tick cycle.
// Optional BTN_PRIORITY_EN: when several buttons arm on one tick, only the lowest index pulses.
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_TICKS  = 3,
  parameter bit          RAW_ACTIVE_HIGH = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_100hz,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic               btn_0_p,
  output logic               btn_1_p,
  output logic               btn_2_p,
  output logic               btn_3_p,
  output logic [NUM_BTN-1:0] btn_level
);

  logic [NUM_BTN-1:0] arm;
  logic [NUM_BTN-1:0] arm_sel;
  logic [NUM_BTN-1:0] pulse_q;

  for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .RAW_ACTIVE_HIGH(RAW_ACTIVE_HIGH)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick_100hz),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .arm_c(arm[i])
    );
  end

`ifdef BTN_PRIORITY_EN
  // Isolate the lowest set bit so at most one pulse is ever high.
  assign arm_sel = arm & (~arm + NUM_BTN'(1));
`else
  assign arm_sel = arm;
`endif

  // Pulse register only updates on ticks, so a pulse spans exactly one tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= '0;
    end else if (tick_100hz) begin
      pulse_q <= arm_sel;
    end
  end

  assign btn_0_p = pulse_q[0];
  assign btn_1_p = pulse_q[1];
  assign btn_2_p = pulse_q[2];
  assign btn_3_p = pulse_q[3];

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: directed scenarios with literal expectations plus randomized
// stimulus against a run-length debounce model. Honours BTN_PRIORITY_EN when defined.
module tb_btn_pulse_gen;

  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned DEBOUNCE_TICKS = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_100hz;
  logic [3:0] btn_raw;
  logic       btn_0_p, btn_1_p, btn_2_p, btn_3_p;
  logic [3:0] btn_level;
  logic [3:0] dut_p;

  int tests = 0;
  int fails = 0;
  int pcnt[4];

  assign dut_p = {btn_3_p, btn_2_p, btn_1_p, btn_0_p};

  btn_pulse_gen #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .RAW_ACTIVE_HIGH(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_100hz(tick_100hz),
    .btn_raw   (btn_raw),
    .btn_0_p   (btn_0_p),
    .btn_1_p   (btn_1_p),
    .btn_2_p   (btn_2_p),
    .btn_3_p   (btn_3_p),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a level flips once the synced sample has disagreed with it on
  // DEBOUNCE_TICKS+1 consecutive ticks; accepted presses pulse on the next tick cycle.
  logic [3:0] sq[$];
  logic [3:0] m_level, m_pulse, m_s, m_rise;
  int         run[4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_level = '0;
      m_pulse = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      sq.delete();
      repeat (SYNC_STAGES) sq.push_back(4'b0);
    end else begin
      m_s = sq.pop_front();
      sq.push_back(btn_raw);
      if (tick_100hz) begin
        m_rise = '0;
        for (int i = 0; i < 4; i++) begin
          if (m_s[i] != m_level[i]) begin
            run[i]++;
            if (run[i] == int'(DEBOUNCE_TICKS) + 1) begin
              m_level[i] = m_s[i];
              m_rise[i]  = m_s[i];
              run[i]     = 0;
            end
          end else begin
            run[i] = 0;
          end
        end
`ifdef BTN_PRIORITY_EN
        m_pulse = m_rise & (~m_rise + 4'd1);
`else
        m_pulse = m_rise;
`endif
      end
    end
  end

  // Every-cycle comparison against the model, plus tick-qualified pulse counting.
  always @(negedge clk) begin
    chk("level_vs_model", int'(btn_level), int'(m_level));
    chk("pulse_vs_model", int'(dut_p), int'(m_pulse));
    if (tick_100hz && rst_n) begin
      for (int i = 0; i < 4; i++) if (dut_p[i]) pcnt[i]++;
    end
  end

  // n tick periods of four clocks each, the tick on the last clock.
  task automatic do_tick(input int n);
    repeat (n) begin
      tick_100hz = 1'b0;
      repeat (3) @(posedge clk);
      #2 tick_100hz = 1'b1;
      @(posedge clk);
      #2 tick_100hz = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) pcnt[i] = 0;
    rst_n      = 1'b0;
    tick_100hz = 1'b0;
    btn_raw    = 4'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("reset_level", int'(btn_level), 0);
    chk("reset_pulse", int'(dut_p), 0);

    // Idle 20 ticks
    do_tick(20);
    chk("idle_level", int'(btn_level), 0);
    chk("idle_pulses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);

    // Single press of button 2
    btn_raw = 4'b0100;
    do_tick(3);
    chk("b2_level_early", int'(btn_level[2]), 0);
    do_tick(1);
    chk("b2_level_set", int'(btn_level[2]), 1);
    chk("b2_pulse_high", int'(btn_2_p), 1);
    do_tick(1);
    chk("b2_pulse_low", int'(btn_2_p), 0);
    chk("b2_pulse_count", pcnt[2], 1);
    do_tick(5);
    chk("b2_no_repeat", pcnt[2], 1);
    btn_raw = 4'b0;
    do_tick(5);
    chk("b2_released", int'(btn_level[2]), 0);

    // Bounce on button 1
    repeat (5) begin
      btn_raw[1] = 1'b1;
      do_tick(2);
      btn_raw[1] = 1'b0;
      do_tick(1);
    end
    chk("b1_bounce_pulses", pcnt[1], 0);
    chk("b1_bounce_level", int'(btn_level[1]), 0);

    // Long hold of button 0, then release
    btn_raw[0] = 1'b1;
    do_tick(200);
    chk("b0_hold_pulses", pcnt[0], 1);
    btn_raw[0] = 1'b0;
    do_tick(3);
    chk("b0_level_held", int'(btn_level[0]), 1);
    do_tick(1);
    chk("b0_level_fall", int'(btn_level[0]), 0);
    chk("b0_release_no_pulse", pcnt[0], 1);

    // Simultaneous press of buttons 1 and 3
    do_tick(5);
    btn_raw = 4'b1010;
    do_tick(4);
    chk("dual_level", int'(btn_level), 10);
    chk("dual_b1_pulse", int'(btn_1_p), 1);
`ifdef BTN_PRIORITY_EN
    chk("dual_b3_pulse", int'(btn_3_p), 0);
`else
    chk("dual_b3_pulse", int'(btn_3_p), 1);
`endif
    do_tick(1);
    chk("dual_pulse_clear", int'(dut_p), 0);
    btn_raw = 4'b0;
    do_tick(6);

    // Reset while a pulse is high, button held through reset
    btn_raw = 4'b0100;
    do_tick(4);
    chk("rst_pre_pulse", int'(btn_2_p), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_pulse_cleared", int'(btn_2_p), 0);
    chk("rst_level_cleared", int'(btn_level), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    do_tick(3);
    chk("rst_requal_early", int'(btn_2_p), 0);
    do_tick(1);
    chk("rst_requal_pulse", int'(btn_2_p), 1);
    btn_raw = 4'b0;
    do_tick(6);

    // Randomized buttons and irregular tick spacing
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #2;
      tick_100hz = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) btn_raw = btn_raw ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) btn_raw = 4'($urandom_range(0, 15));
    end
    tick_100hz = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
